// File: rtl/cplx_mac.sv
// Pipelined complex multiply-accumulate: one term per cycle, fixed-point dot products
// with round-half-up and saturation to DATA_W bits on the final term.
module cplx_mac #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 13,
    parameter int GUARD_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_sat
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int ACC_W  = SUM_W + GUARD_W;
    localparam int RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] HALF    = RND_W'(1) << (FRAC_W - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX = {{(RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN = {{(RND_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic stall;
    logic s1_valid, s1_last;
    logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [ACC_W-1:0]  acc_re, acc_im;
    logic signed [SUM_W-1:0]  term_re, term_im;
    logic signed [ACC_W-1:0]  sum_re, sum_im;
    logic [DATA_W:0]          fin_re, fin_im;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Returns {clamped, value}: round half up at FRAC_W, then clamp to DATA_W signed.
    function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] v);
        logic signed [RND_W-1:0] r;
        r = (RND_W'(v) + HALF) >>> FRAC_W;
        if (r > SAT_MAX)
            return {1'b1, SAT_MAX[DATA_W-1:0]};
        else if (r < SAT_MIN)
            return {1'b1, SAT_MIN[DATA_W-1:0]};
        else
            return {1'b0, r[DATA_W-1:0]};
    endfunction

    // Stage 1: four full-width products; the whole pipe freezes while the output is stalled.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_last  <= in_valid && in_last;
            if (in_valid) begin
                p_rr <= $signed(PROD_W'(a_re)) * $signed(PROD_W'(b_re));
                p_ii <= $signed(PROD_W'(a_im)) * $signed(PROD_W'(b_im));
                p_ri <= $signed(PROD_W'(a_re)) * $signed(PROD_W'(b_im));
                p_ir <= $signed(PROD_W'(a_im)) * $signed(PROD_W'(b_re));
            end
        end
    end

    // NOTE: every combinational output is assigned on all paths, so no latch can be inferred.
    always_comb begin
        term_re = SUM_W'(p_rr) - SUM_W'(p_ii);
        term_im = SUM_W'(p_ri) + SUM_W'(p_ir);
        sum_re  = acc_re + ACC_W'(term_re);
        sum_im  = acc_im + ACC_W'(term_im);
        fin_re  = round_sat(sum_re);
        fin_im  = round_sat(sum_im);
    end

    // Stage 2: accumulate, or on the last term publish the rounded sum and restart from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_re    <= '0;
            acc_im    <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            if (s1_valid && s1_last) begin
                acc_re    <= '0;
                acc_im    <= '0;
                out_valid <= 1'b1;
                out_re    <= fin_re[DATA_W-1:0];
                out_im    <= fin_im[DATA_W-1:0];
                out_sat   <= fin_re[DATA_W] | fin_im[DATA_W];
            end else begin
                if (s1_valid) begin
                    acc_re <= sum_re;
                    acc_im <= sum_im;
                end
                if (out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cplx_mac.sv
// Directed bench for cplx_mac: an arithmetic dot-product model checks every handshaken
// result, and literal expectations pin latency, rounding, saturation and backpressure.
module tb_cplx_mac;

    localparam int DATA_W  = 16;
    localparam int FRAC_W  = 13;
    localparam int GUARD_W = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     in_last = 1'b0;
    logic signed [DATA_W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [DATA_W-1:0] out_re, out_im;
    logic                     out_sat;

    int checks   = 0;
    int failures = 0;

    longint m_acc_re = 0, m_acc_im = 0;
    longint exp_re[$];
    longint exp_im[$];
    longint exp_sat[$];

    cplx_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .GUARD_W(GUARD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Real-number view: value = floor(sum / 2^FRAC_W + 1/2), then clamp to the output range.
    function automatic longint to_output(input longint sum, output longint sat);
        longint d, n, q, hi, lo;
        d  = longint'(1) << FRAC_W;
        n  = sum + d / 2;
        q  = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        hi = (longint'(1) << (DATA_W - 1)) - 1;
        lo = -(longint'(1) << (DATA_W - 1));
        sat = 0;
        if (q > hi) begin q = hi; sat = 1; end
        if (q < lo) begin q = lo; sat = 1; end
        return q;
    endfunction

    // Model and compare process, sampled on the falling edge where inputs and outputs are stable.
    always @(negedge clk) begin
        longint ar, ai, br, bi, r, s_re, s_im;
        if (!rst_n) begin
            m_acc_re = 0;
            m_acc_im = 0;
            exp_re.delete();
            exp_im.delete();
            exp_sat.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_re.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("model_re",  longint'(out_re), exp_re.pop_front());
                    check("model_im",  longint'(out_im), exp_im.pop_front());
                    check("model_sat", longint'(out_sat), exp_sat.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                ar = a_re; ai = a_im; br = b_re; bi = b_im;
                m_acc_re += ar * br - ai * bi;
                m_acc_im += ar * bi + ai * br;
                if (in_last) begin
                    r = to_output(m_acc_re, s_re);
                    exp_re.push_back(r);
                    r = to_output(m_acc_im, s_im);
                    exp_im.push_back(r);
                    exp_sat.push_back(s_re | s_im);
                    m_acc_re = 0;
                    m_acc_im = 0;
                end
            end
        end
    end

    // Presents a term and returns on the falling edge before the edge that accepts it.
    task automatic send(input int ar, input int ai, input int br, input int bi, input bit last);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_last  = last;
        a_re = DATA_W'(ar); a_im = DATA_W'(ai);
        b_re = DATA_W'(br); b_im = DATA_W'(bi);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Call right after sending a last term: nothing one cycle later, the result two cycles later.
    task automatic expect_out(input string name, input longint re, input longint im, input longint sat);
        idle();
        @(negedge clk);
        check({name, "_early"}, longint'(out_valid), 0);
        @(negedge clk);
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_re"},    longint'(out_re), re);
        check({name, "_im"},    longint'(out_im), im);
        check({name, "_sat"},   longint'(out_sat), sat);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_in_ready",  longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_re",    longint'(out_re), 0);
        check("rst_out_im",    longint'(out_im), 0);
        check("rst_out_sat",   longint'(out_sat), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", longint'(in_ready), 1);

        // Basic single term: (1+j)(1-j) = 2
        send(8192, 8192, 8192, -8192, 1);
        expect_out("basic", 16384, 0, 0);

        // Four-term accumulate, no output until the last
        for (int i = 0; i < 4; i++) begin
            send(4096, 0, 4096, 0, i == 3);
            check("acc_no_early_out", longint'(out_valid), 0);
        end
        expect_out("accum", 8192, 0, 0);

        // Saturation both ways
        send(28672, 0, 28672, 0, 1);
        expect_out("sat_pos", 32767, 0, 1);
        send(28672, 0, -28672, 0, 1);
        expect_out("sat_neg", -32768, 0, 1);

        // Round half up on both signs
        send(1, 0, 4096, 0, 1);
        expect_out("round_pos", 1, 0, 0);
        send(-1, 0, 4096, 0, 1);
        expect_out("round_neg", 0, 0, 0);

        // Back-to-back products with no idle cycle, including one that saturates by accumulation
        send(8192, 0, 8192, 0, 0);
        send(8192, 8192, 8192, 0, 1);
        send(-4096, 0, 8192, 0, 1);
        send(12288, 0, 12288, 0, 0);
        send(12288, 0, 12288, 0, 1);
        idle();
        repeat (4) @(negedge clk);

        // Backpressure: first result stalls, a second waits in stage 1, a third at the input
        @(posedge clk); #1 out_ready = 1'b0;
        send(8192, 0, 4096, 4096, 1);
        send(-8192, 8192, 8192, 8192, 1);
        @(posedge clk); #1;
        a_re = 16'sd4096; a_im = '0; b_re = 16'sd4096; b_im = '0;
        in_valid = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready",  longint'(in_ready), 0);
            check("bp_out_valid", longint'(out_valid), 1);
            check("bp_out_re",    longint'(out_re), 4096);
            check("bp_out_im",    longint'(out_im), 4096);
            check("bp_out_sat",   longint'(out_sat), 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", longint'(in_ready), 1);
        idle();
        @(negedge clk);
        check("bp_second_valid", longint'(out_valid), 1);
        check("bp_second_re",    longint'(out_re), -16384);
        @(negedge clk);
        check("bp_third_re",     longint'(out_re), 2048);

        // Reset in the middle of a three-term product
        send(8192, 0, 8192, 0, 0);
        send(8192, 0, 8192, 0, 0);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  longint'(in_ready), 1);
        check("midrst_out_valid", longint'(out_valid), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(8192, 0, 8192, 0, 1);
        expect_out("midrst", 8192, 0, 0);

        // Drain, then outputs must hold once out_valid drops
        repeat (5) @(negedge clk);
        check("queue_drained",  longint'(exp_re.size()), 0);
        check("hold_out_valid", longint'(out_valid), 0);
        check("hold_out_re",    longint'(out_re), 8192);
        check("hold_out_im",    longint'(out_im), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
